// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit that owns HI/LO; one result bit per cycle.
// Define MDU_MULT_EN to build the MULT/MULTU datapath; without it only DIV/DIVU start.
module ex_muldiv_unit #(
  parameter int NBit = 32,
  parameter int CntW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [NBit-1:0] a,
  input  logic [NBit-1:0] b,
  input  logic            hilo_rd,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [NBit-1:0] wdata,
  output logic            busy,
  output logic            stall_req,
  output logic [NBit-1:0] hi,
  output logic [NBit-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CntW-1:0]   cnt;
  logic [NBit-1:0]   rem, rem_nxt;
  logic [NBit-1:0]   quo, quo_nxt;
  logic [NBit-1:0]   dvs;
  logic              sign_a, sign_b;
  logic              start_ok, load, step, commit, mt_en;
  logic              a_neg, b_neg;
  logic [NBit-1:0]   a_mag, b_mag;
  logic [NBit:0]     rem_shift, diff;
  logic [NBit-1:0]   q_fix, r_fix, hi_res, lo_res;

`ifdef MDU_MULT_EN
  logic              is_mul;
  logic [NBit:0]     sum;
  logic [2*NBit-1:0] prod, prod_fix;
  assign start_ok = start;
`else
  assign start_ok = start & ~op[1];
`endif

  // Handshake: EX holds start/hilo_rd/mthi/mtlo until a cycle with busy=0; stall_req
  // freezes IF/ID and ID/EX and bubbles EX/MEM, so nothing is accepted while busy.
  assign stall_req = busy & (start | hilo_rd | mthi | mtlo);

  assign a_neg = op[0] & a[NBit-1];
  assign b_neg = op[0] & b[NBit-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (cnt == CntW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    mt_en  = 1'b0;
    case (state)
      IDLE: begin
        load  = start_ok;
        mt_en = ~start;
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      FIX: begin
        busy   = 1'b1;
        commit = 1'b1;
      end
      default: ;
    endcase
  end

  // Dividend/multiplier shifts through quo; rem is the remainder or upper product half.
  always_comb begin
    rem_shift = {rem, quo[NBit-1]};
    diff      = rem_shift - {1'b0, dvs};
    if (diff[NBit]) begin
      rem_nxt = rem_shift[NBit-1:0];
      quo_nxt = {quo[NBit-2:0], 1'b0};
    end else begin
      rem_nxt = diff[NBit-1:0];
      quo_nxt = {quo[NBit-2:0], 1'b1};
    end
`ifdef MDU_MULT_EN
    sum = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
    if (is_mul) begin
      rem_nxt = sum[NBit:1];
      quo_nxt = {sum[0], quo[NBit-1:1]};
    end
`endif
  end

  // With a zero divisor rem ends up holding |a|, so the signed fix-up restores raw a.
  always_comb begin
    q_fix  = (sign_a ^ sign_b) ? -quo : quo;
    r_fix  = sign_a ? -rem : rem;
    hi_res = r_fix;
    lo_res = (dvs == '0) ? '1 : q_fix;
`ifdef MDU_MULT_EN
    prod     = {rem, quo};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    if (is_mul) begin
      hi_res = prod_fix[2*NBit-1:NBit];
      lo_res = prod_fix[NBit-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (load) begin
      cnt    <= CntW'(NBit);
      rem    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      sign_a <= a_neg;
      sign_b <= b_neg;
    end else if (step) begin
      cnt <= cnt - CntW'(1);
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

`ifdef MDU_MULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    is_mul <= 1'b0;
    else if (load) is_mul <= op[1];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (mt_en) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed literal cases plus randomized traffic against a
// cycle-level arithmetic model; MULT cases depend on MDU_MULT_EN.
module tb_ex_muldiv_unit;
  localparam int NBIT = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [NBIT-1:0] a = '0;
  logic [NBIT-1:0] b = '0;
  logic            hilo_rd = 1'b0;
  logic            mthi = 1'b0;
  logic            mtlo = 1'b0;
  logic [NBIT-1:0] wdata = '0;
  logic            busy, stall_req;
  logic [NBIT-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.NBit(NBIT), .CntW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    int sx, sy;
    longint unsigned pu;
    longint ps;
    sx = $signed(x);
    sy = $signed(y);
    ref_op = '0;
    case (o)
      2'b00: ref_op = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      2'b01: begin
        if (y == 0)                                     ref_op = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)         ref_op = {32'h0, 32'h8000_0000};
        else                                            ref_op = {32'(sx % sy), 32'(sx / sy)};
      end
      2'b10: begin pu = {32'd0, x} * {32'd0, y}; ref_op = pu; end
      default: begin ps = longint'(sx) * longint'(sy); ref_op = ps; end
    endcase
  endfunction

  function automatic bit op_supported(input logic [1:0] o);
`ifdef MDU_MULT_EN
    return 1'b1;
`else
    return !o[1];
`endif
  endfunction

  // scoreboard: pending results and architectural HI/LO as the spec defines them
  logic [63:0] exp_q[$];
  int          m_busy;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_hi   = '0;
      m_lo   = '0;
      exp_q.delete();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && exp_q.size() > 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (start) begin
      if (op_supported(op)) begin
        exp_q.push_back(ref_op(op, a, b));
        m_busy = NBIT + 1;
      end
    end else begin
      if (mthi) m_hi = wdata;
      if (mtlo) m_lo = wdata;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cyc_busy", busy, m_busy > 0);
      check("cyc_stall_req", stall_req, (m_busy > 0) && (start || hilo_rd || mthi || mtlo));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // driver tasks
  task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic write_hilo(input logic [31:0] d);
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_stall", stall_req, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_start(2'b00, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_latency", 64'(n), 33);
    check("divu_lo", lo, 14);
    check("divu_hi", hi, 2);

    do_start(2'b01, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    do_start(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 0);

    do_start(2'b00, 32'h1234, 32'h0);
    wait_idle(n);
    check("div0_latency", 64'(n), 33);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234);

`ifdef MDU_MULT_EN
    do_start(2'b11, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    check("mult_latency", 64'(n), 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    do_start(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h1);
`else
    do_start(2'b11, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mult_ignored_busy", busy, 0);
    end
    check("mult_ignored_hi", hi, 32'h1234);
    check("mult_ignored_lo", lo, 32'hFFFF_FFFF);
`endif

    // MFHI/MFLO interlock: read asserted from the second busy cycle onward
    do_start(2'b00, 32'd1000, 32'd10);
    @(posedge clk); #1 hilo_rd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin
        check("hilo_stall", stall_req, 1);
      end else begin
        check("hilo_release_stall", stall_req, 0);
        check("hilo_release_lo", lo, 100);
        check("hilo_release_hi", hi, 0);
        break;
      end
    end
    @(posedge clk); #1 hilo_rd = 1'b0;

    write_hilo(32'hA5A5_A5A5);
    @(negedge clk);
    check("mt_hi", hi, 32'hA5A5_A5A5);
    check("mt_lo", lo, 32'hA5A5_A5A5);

    // start wins over same-cycle MTHI/MTLO; HI/LO hold through RUN
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd3;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check("prio_hold_hi", hi, 32'hA5A5_A5A5);
    check("prio_hold_lo", lo, 32'hA5A5_A5A5);
    wait_idle(n);
    check("prio_lo", lo, 3);
    check("prio_hi", hi, 0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom_range(0, 3));
      a       = rnd_operand();
      b       = rnd_operand();
      hilo_rd = ($urandom_range(0, 3) == 0);
      mthi    = ($urandom_range(0, 7) == 0);
      mtlo    = ($urandom_range(0, 7) == 0);
      wdata   = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_rd = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_idle(n);

    // asynchronous reset in the middle of a division
    write_hilo(32'h5A5A_5A5A);
    do_start(2'b00, 32'd50, 32'd3);
    repeat (10) @(posedge clk);
    #2 hilo_rd = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("midrun_busy", busy, 0);
    check("midrun_stall", stall_req, 0);
    check("midrun_hi", hi, 0);
    check("midrun_lo", lo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; hilo_rd = 1'b0;

    do_start(2'b00, 32'd200, 32'd9);
    wait_idle(n);
    check("post_reset_lo", lo, 22);
    check("post_reset_hi", hi, 2);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage; owns the architectural HI/LO registers.
- Its stall request drives the enable of the upstream pipeline interface registers (IF/ID, ID/EX).
- The EX/MEM interface register receives a bubble while stalled.
- One result bit per cycle, so EX area stays small; reads of HI/LO interlock against an in-flight operation.

Parameters:
- NBit, 32, operand/result width; must be even and ≥4.
- CntW, 6, iteration counter width; must satisfy 2^CntW > NBit.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a mult/div instruction this cycle.
- op  input  2  00 DIVU, 01 DIV, 10 MULTU, 11 MULT.
- a  input  NBit  rs operand (dividend / multiplicand).
- b  input  NBit  rt operand (divisor / multiplier).
- hilo_rd  input  1  EX holds MFHI/MFLO.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  NBit  MTHI/MTLO data.
- busy  output  1  operation in flight.
- stall_req  output  1  stall upstream stages; bubble EX/MEM.
- hi  output  NBit  HI register.
- lo  output  NBit  LO register.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, counter=0, busy=0; an in-flight operation is discarded.
- FSM IDLE:
  - start=1 latches operands as magnitudes (absolute values for signed ops) plus sign flags, loads counter=NBit, goes to RUN.
  - start has priority over mthi/mtlo in the same cycle; the mt writes are dropped.
  - Otherwise mthi/mtlo write HI/LO on the clock edge; both may assert in the same cycle.
- FSM RUN, one iteration per cycle, counter decrements:
  - Division: restoring shift-subtract on an NBit+1-bit partial remainder.
  - Multiplication: shift-add on a 2*NBit accumulator.
  - When counter reaches 1, go to FIX.
- FSM FIX:
  - Apply sign correction.
  - Write hi/lo: quotient→lo, remainder→hi; or product upper half→hi, lower half→lo.
  - Return to IDLE.
- Timing:
  - busy=1 in RUN and FIX, i.e. NBit+1 cycles starting the cycle after start.
  - hi/lo are valid the cycle after FIX.
  - start, hilo_rd and mthi/mtlo may all be accepted in the first cycle busy=0.
- stall_req = busy & (start | hilo_rd | mthi | mtlo), combinational.
  - start while busy is not accepted; the instruction is held by the stall.
  - Upstream uses stall_req as !en; EX/MEM uses it as nop.
- Sign rules (DIV/MULT):
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Product negated when operand signs differ.
  - Unsigned ops ignore sign.
- Divide by zero, both signednesses: lo = all ones, hi = a (raw operand); takes the full latency; no exception.
- Signed overflow, most-negative / -1: lo = 0x8000_0000, hi = 0 (NBit=32).
- hi/lo are held unchanged during RUN; they update only in FIX or by mthi/mtlo in IDLE.

Optional Feature:
- MDU_MULT_EN defined:
  - MULT/MULTU are supported as described above.
- MDU_MULT_EN not defined:
  - Multiply datapath is removed.
  - start with op[1]=1 is ignored: no state change, busy stays 0, hi/lo are unchanged.
  - DIV/DIVU behaviour is unaffected.

Test Plan:
- DIVU a=100, b=7, one-cycle start pulse → busy=1 for exactly 33 cycles; then lo=14, hi=2.
- DIV a=-7 (0xFFFF_FFF9), b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV a=0x8000_0000, b=-1 → lo=0x8000_0000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFF_FFFF, hi=0x1234, after full 33-cycle latency.
- MULT a=-3, b=5 (MDU_MULT_EN defined) → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. MULTU a=b=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=1. Without the macro: start ignored, busy stays 0.
- hilo_rd asserted cycle 2 after a DIVU start → stall_req=1 until busy falls; stall_req=0 on the first cycle busy=0, and lo reads the new quotient.
- rst_n pulsed low mid-RUN → busy, hi, lo, stall_req go to 0 immediately. mthi=mtlo=1 with wdata=0xA5A5_A5A5 in IDLE → hi=lo=0xA5A5_A5A5 next cycle.
